led_pattern_sched: RTL and testbench

Scheduler that shares the board's single status LED between several requesters, each of which wants to flash a short blink code (N blinks). It owns the tick prescaler driven by the low-frequency oscillator clock. It grants the LED to one requester at a time using round-robin arbitration, and plays that requester's code. It shows an optional heartbeat while idle. It sits between the on-chip oscillator and the LED pad, replacing a free-running blinker.

---
 rtl/led_sched_pkg.sv | 14 +
 rtl/led_tick_gen.sv | 29 ++
 rtl/led_pattern_sched.sv | 144 ++++++++++++++
 tb/tb_led_pattern_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and constants for the status-LED blink-code scheduler.
package led_sched_pkg;

    typedef logic [1:0] led_state_t;

    localparam led_state_t IDLE = 2'd0;
    localparam led_state_t ON   = 2'd1;
    localparam led_state_t OFF  = 2'd2;
    localparam led_state_t GAP  = 2'd3;

    localparam int BLINK_W   = 4;
    localparam int GAP_TICKS = 2;

endpackage

// File: rtl/led_tick_gen.sv
// Blink-phase prescaler: counts 0..TICK_DIV-1, flags the last count as tick.
module led_tick_gen #(
    parameter int TICK_DIV = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/led_pattern_sched.sv
// Round-robin owner of the single status LED; plays N-blink codes per requester.
// Optional idle heartbeat enabled by defining LED_SCHED_HEARTBEAT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests (heartbeat if enabled)
// ON    | LED lit for one blink phase
// OFF   | LED dark for one blink phase, then count down remaining blinks
// GAP   | LED dark for GAP_TICKS phases, done pulses in the final cycle
module led_pattern_sched
    import led_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TICK_DIV = 5000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [BLINK_W*NREQ-1:0] blinks,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic                    led
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    led_state_t           state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        ptr_next;
    logic [NREQ-1:0]      win_onehot;
    logic [BLINK_W-1:0]   win_blinks;
    logic [BLINK_W-1:0]   rem;
    logic [1:0]           gap_left;
    logic                 win_found;
    logic                 grant;
    logic                 tick;
    logic                 tick_en;
    logic                 done_now;
    int                   pick_idx;

    // Search starts at ptr, which always holds the index after the last winner.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_blinks = '0;
        pick_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pick_idx = (int'(ptr) + i) % NREQ;
            if (!win_found && req[pick_idx]) begin
                win_found            = 1'b1;
                win_idx              = PW'(pick_idx);
                win_onehot[pick_idx] = 1'b1;
                win_blinks           = blinks[BLINK_W*pick_idx +: BLINK_W];
            end
        end
    end

    assign ptr_next = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
    assign grant    = (state == IDLE) && win_found;

`ifdef LED_SCHED_HEARTBEAT_EN
    assign tick_en = 1'b1;
`else
    assign tick_en = (state != IDLE);
`endif

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant),
        .en    (tick_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            rem      <= '0;
            gap_left <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt      <= win_onehot;
                        busy     <= 1'b1;
                        rem      <= win_blinks;
                        ptr      <= ptr_next;
                        gap_left <= 2'(GAP_TICKS - 1);
                        state    <= (win_blinks != '0) ? ON : GAP;
                    end
                end
                ON: begin
                    if (tick) state <= OFF;
                end
                OFF: begin
                    if (tick) begin
                        rem   <= rem - 1'b1;
                        state <= (rem != BLINK_W'(1)) ? ON : GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_left == '0) begin
                            state <= IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            gap_left <= gap_left - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // LED follows the state one cycle later, so a grant at edge k lights it from k+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= 1'b0;
        end else if (state == IDLE) begin
`ifdef LED_SCHED_HEARTBEAT_EN
            if (win_found)  led <= 1'b0;
            else if (tick)  led <= ~led;
`else
            led <= 1'b0;
`endif
        end else begin
            led <= (state == ON);
        end
    end

    // Decoded from flops only so the pulse coincides with the last GAP cycle.
    assign done_now = (state == GAP) && (gap_left == '0) && tick;
    assign done     = done_now ? gnt : '0;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench for led_pattern_sched with TICK_DIV=4, NREQ=4.
module tb_led_pattern_sched;

    localparam int NREQ     = 4;
    localparam int TICK_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] blinks;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        led;

    int checks = 0;
    int errors = 0;

    led_pattern_sched #(
        .NREQ     (NREQ),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .blinks (blinks),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = '0;
        blinks = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = 4'hF;
        blinks = 16'h2222;
        @(negedge clk);
        checks++;
        if ({led, busy, gnt, done} !== 10'b0) begin
            errors++;
            $display("FAIL reset_hold got led=%b busy=%b gnt=%b done=%b exp all 0", led, busy, gnt, done);
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({led, busy, gnt, done} !== 10'b0) begin
            errors++;
            $display("FAIL reset_idle got led=%b busy=%b gnt=%b done=%b exp all 0", led, busy, gnt, done);
        end
    endtask

    // Runs one pattern of n blinks for the requester with one-hot id; cycle 1 is the first after the grant edge.
    task automatic run_pattern(input string name, input int n, input logic [3:0] id,
                               input int change_cycle, input logic [15:0] new_blinks);
        logic [9:0] got, exp;
        logic       exp_led;
        int         ndone;
        ndone = 0;
        for (int c = 1; c <= 8 * n + 10; c++) begin
            @(negedge clk);
            if (c == change_cycle) begin
                req    = '0;
                blinks = new_blinks;
            end
            exp_led = (c >= 2) && (c <= 8 * n + 1) && (((c - 2) % 8) < 4);
            exp = {exp_led, (c <= 8 * n + 8), (c <= 8 * n + 8) ? id : 4'b0, (c == 8 * n + 8) ? id : 4'b0};
            got = {led, busy, gnt, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d got led/busy/gnt/done=%b exp %b", name, c, got, exp);
            end
            if (done != 4'b0) ndone++;
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL %s done_count got %0d exp 1", name, ndone);
        end
    endtask

    task automatic test_single();
        do_reset();
        blinks = 16'h0002;
        req    = 4'b0001;
        run_pattern("single", 2, 4'b0001, 1, 16'h0002);
    endtask

    task automatic test_zero_blinks();
        do_reset();
        blinks = 16'h0050;
        blinks[7:4] = 4'd0;
        req    = 4'b0010;
        run_pattern("zero_blinks", 0, 4'b0010, 1, 16'h0000);
    endtask

    task automatic test_mid_change();
        do_reset();
        blinks = 16'h0003;
        req    = 4'b0001;
        run_pattern("mid_change", 3, 4'b0001, 2, 16'h0001);
    endtask

    task automatic test_round_robin();
        logic [3:0] prev, exp;
        int         ng;
        do_reset();
        blinks = 16'h1111;
        req    = 4'hF;
        prev   = '0;
        ng     = 0;
        for (int c = 0; c < 120 && ng < 5; c++) begin
            @(negedge clk);
            if (gnt != 4'b0 && prev == 4'b0) begin
                exp = 4'b0001 << (ng % 4);
                checks++;
                if (gnt !== exp) begin
                    errors++;
                    $display("FAIL rr_grant%0d got %b exp %b", ng, gnt, exp);
                end
                ng++;
            end
            if (gnt != 4'b0 && prev != 4'b0 && gnt != prev) begin
                checks++;
                errors++;
                $display("FAIL rr_idle_gap got %b after %b exp 0000 between", gnt, prev);
            end
            if (done != 4'b0) begin
                checks++;
                if (done !== gnt) begin
                    errors++;
                    $display("FAIL rr_done got %b exp %b", done, gnt);
                end
            end
            prev = gnt;
        end
        checks++;
        if (ng !== 5) begin
            errors++;
            $display("FAIL rr_timeout got %0d grants exp 5", ng);
        end
        req = '0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        blinks = 16'h0002;
        req    = 4'b0001;
        repeat (5) @(negedge clk);
        checks++;
        if ({led, busy, gnt} !== 6'b11_0001) begin
            errors++;
            $display("FAIL mid_reset_pre got led=%b busy=%b gnt=%b exp 1 1 0001", led, busy, gnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led, busy, gnt, done} !== 10'b0) begin
            errors++;
            $display("FAIL mid_reset_now got led=%b busy=%b gnt=%b done=%b exp all 0", led, busy, gnt, done);
        end
        req    = 4'hF;
        blinks = 16'h2222;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 4'b0) begin
                errors++;
                $display("FAIL mid_reset_done got %b exp 0000", done);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, gnt} !== 5'b1_0001) begin
            errors++;
            $display("FAIL mid_reset_regrant got busy=%b gnt=%b exp 1 0001", busy, gnt);
        end
        req = '0;
    endtask

    task automatic test_heartbeat();
        logic exp_led;
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
`ifdef LED_SCHED_HEARTBEAT_EN
            exp_led = ((c / 4) % 2) == 1;
`else
            exp_led = 1'b0;
`endif
            checks++;
            if (led !== exp_led || busy !== 1'b0) begin
                errors++;
                $display("FAIL heartbeat cycle %0d got led=%b busy=%b exp led=%b busy=0", c, led, busy, exp_led);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        req    = '0;
        blinks = '0;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_blinks();
        test_mid_change();
        test_mid_reset();
        test_heartbeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
